// File: rtl/link_codec_pkg.sv
// Shared 3-bit code / 8-bit one-hot definitions for both ends of the encoded link.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package link_codec_pkg;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;

    typedef logic [CODE_W-1:0]   code_t;
    typedef logic [ONEHOT_W-1:0] onehot_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_state_t;

    // The transmit-side encoder relies on this being the exact inverse mapping.
    function automatic onehot_t code2onehot(input code_t code);
        return onehot_t'(1) << code;
    endfunction

endpackage

// File: rtl/link_fifo.sv
// Generic synchronous FIFO with an EMPTY/PARTIAL/FULL occupancy FSM.
// Latency: written entry is visible at rd_dat the cycle after the push edge.
// Backpressure: push ignored while full (even with a simultaneous pop); pop ignored while empty.
module link_fifo
    import link_codec_pkg::*;
#(
    parameter int WIDTH = CODE_W,
    parameter int DEPTH = 4,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty,
    output logic [OCC_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] LAST_FREE = OCC_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] ONE       = OCC_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    occ_state_t       state;
    occ_state_t       state_nxt;
    logic             do_push;
    logic             do_pop;

    assign full    = (state == OCC_FULL);
    assign empty   = (state == OCC_EMPTY);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_dat  = mem[rd_ptr];

    always_comb begin
        state_nxt = state;
        case (state)
            OCC_EMPTY: begin
                if (do_push)
                    state_nxt = OCC_PARTIAL;
            end
            OCC_PARTIAL: begin
                if (do_push && !do_pop && count == LAST_FREE)
                    state_nxt = OCC_FULL;
                else if (do_pop && !do_push && count == ONE)
                    state_nxt = OCC_EMPTY;
            end
            OCC_FULL: begin
                if (do_pop)
                    state_nxt = OCC_PARTIAL;
            end
            default: state_nxt = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= OCC_EMPTY;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the read side is qualified by empty.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/link_decoder.sv
// Link receive end: buffers 3-bit codes, presents the FIFO head as a one-hot word. Option: LINK_DECODER_PARITY_EN.
// Latency: symbol pushed at edge N appears on dec_y/dec_valid after edge N; no comb path in_* -> dec_*.
// Backpressure: RDY_in = !full; offers while full are dropped and set sticky ovf.
module link_decoder
    import link_codec_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             in_a2value,
    input  logic             in_a1value,
    input  logic             in_a0value,
    input  logic             in_valid,
    output logic             RDY_in,
    output logic [7:0]       dec_y,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic             ovf,
    output logic [CNT_W-1:0] sym_count
`ifdef LINK_DECODER_PARITY_EN
    ,
    input  logic             in_parity,
    output logic             perr
`endif
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    code_t            in_code;
    code_t            head_code;
    logic             parity_ok;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OCC_W-1:0] fifo_count;

    assign in_code = {in_a2value, in_a1value, in_a0value};

`ifdef LINK_DECODER_PARITY_EN
    assign parity_ok = ^{in_code, in_parity};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            perr <= 1'b0;
        else if (in_valid && RDY_in && !parity_ok)
            perr <= 1'b1;
    end
`else
    assign parity_ok = 1'b1;
`endif

    assign RDY_in    = !fifo_full;
    assign push      = in_valid && RDY_in && parity_ok;
    assign dec_valid = !fifo_empty;
    assign dec_y     = dec_valid ? code2onehot(head_code) : 8'h00;

    link_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (DEPTH),
        .OCC_W (OCC_W)
    ) u_fifo (
        .clk    (CLK),
        .rst_n  (RST_N),
        .push   (push),
        .wr_dat (in_code),
        .pop    (dec_ready),
        .rd_dat (head_code),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf       <= 1'b0;
            sym_count <= '0;
        end else begin
            if (in_valid && !RDY_in)
                ovf <= 1'b1;
            if (push)
                sym_count <= sym_count + CNT_W'(1);
        end
    end

    // Occupancy count and FSM flags must never disagree.
    a_occ_consistent: assert property (@(posedge CLK) disable iff (!RST_N)
        (fifo_count <= OCC_W'(DEPTH)) && ((fifo_count == '0) == fifo_empty)
        && ((fifo_count == OCC_W'(DEPTH)) == fifo_full));

endmodule

// File: tb/tb_link_decoder.sv
// Directed self-checking bench for link_decoder (default depth 4, 16-bit counter).
// Covers reset, decode of all codes, full/overflow, full+pop, steady push/pop, async reset, parity option.
module tb_link_decoder;

    logic        CLK;
    logic        RST_N;
    logic        in_a2value, in_a1value, in_a0value;
    logic        in_valid;
    logic        RDY_in;
    logic [7:0]  dec_y;
    logic        dec_valid;
    logic        dec_ready;
    logic        ovf;
    logic [15:0] sym_count;
`ifdef LINK_DECODER_PARITY_EN
    logic        in_parity;
    logic        perr;
`endif

    int total = 0;
    int bad   = 0;

    link_decoder #(.DEPTH(4), .CNT_W(16)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .in_a2value (in_a2value),
        .in_a1value (in_a1value),
        .in_a0value (in_a0value),
        .in_valid   (in_valid),
        .RDY_in     (RDY_in),
        .dec_y      (dec_y),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .ovf        (ovf),
        .sym_count  (sym_count)
`ifdef LINK_DECODER_PARITY_EN
        ,
        .in_parity  (in_parity),
        .perr       (perr)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] code, input logic rdy);
        in_valid   = v;
        in_a2value = code[2];
        in_a1value = code[1];
        in_a0value = code[0];
        dec_ready  = rdy;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        drive(1'b0, 3'd0, 1'b0);
        #3;
        RST_N = 1'b1;
        tick();
    endtask

    logic [7:0] exp_seq [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] exp_drain [4] = '{8'h20, 8'h02, 8'h80, 8'h01};
    logic [2:0] fill_codes [4] = '{3'd5, 3'd1, 3'd7, 3'd0};
    logic [2:0] model_q [$];
    logic [2:0] k;

    initial begin
        RST_N = 1'b0;
`ifdef LINK_DECODER_PARITY_EN
        in_parity = 1'b0;
`endif
        drive(1'b0, 3'd0, 1'b0);
        #2;
        chk("rst_valid", dec_valid, 1'b0);
        chk("rst_y",     dec_y,     8'h00);
        chk("rst_rdy",   RDY_in,    1'b1);
        chk("rst_ovf",   ovf,       1'b0);
        chk("rst_cnt",   sym_count, 16'd0);
        #2;
        RST_N = 1'b1;
        tick();

        // Codes 0..7 streamed through with the consumer always ready.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 1'b1);
`ifdef LINK_DECODER_PARITY_EN
            in_parity = ~^3'(i);
`endif
            tick();
            chk($sformatf("seq_y%0d", i), dec_y, exp_seq[i]);
            chk($sformatf("seq_v%0d", i), dec_valid, 1'b1);
        end
        drive(1'b0, 3'd0, 1'b1);
        chk("seq_cnt", sym_count, 16'd8);
        chk("seq_ovf", ovf, 1'b0);
        tick();
        chk("seq_empty", dec_valid, 1'b0);
        chk("seq_empty_y", dec_y, 8'h00);

        // Fill to full, overflow with code 3, then drain.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, fill_codes[i], 1'b0);
`ifdef LINK_DECODER_PARITY_EN
            in_parity = ~^fill_codes[i];
`endif
            tick();
        end
        chk("full_rdy", RDY_in, 1'b0);
        chk("full_ovf0", ovf, 1'b0);
        drive(1'b1, 3'd3, 1'b0);
`ifdef LINK_DECODER_PARITY_EN
        in_parity = 1'b1;
`endif
        tick();
        chk("ovf_set", ovf, 1'b1);
        chk("ovf_cnt", sym_count, 16'd4);
        drive(1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_y%0d", i), dec_y, exp_drain[i]);
            tick();
        end
        chk("drain_empty", dec_valid, 1'b0);
        chk("drain_ovf_sticky", ovf, 1'b1);

        // Full with simultaneous pop and offer: offer dropped, RDY_in returns next cycle.
        do_reset();
        fill_codes = '{3'd2, 3'd3, 3'd4, 3'd6};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, fill_codes[i], 1'b0);
`ifdef LINK_DECODER_PARITY_EN
            in_parity = ~^fill_codes[i];
`endif
            tick();
        end
        drive(1'b1, 3'd7, 1'b1);
`ifdef LINK_DECODER_PARITY_EN
        in_parity = 1'b0;
`endif
        tick();
        chk("fp_rdy", RDY_in, 1'b1);
        chk("fp_head", dec_y, 8'h08);
        chk("fp_cnt", sym_count, 16'd4);
        chk("fp_ovf", ovf, 1'b1);
        drive(1'b1, 3'd7, 1'b0);
        tick();
        chk("fp_accept_cnt", sym_count, 16'd5);
        chk("fp_full_again", RDY_in, 1'b0);
        drive(1'b0, 3'd0, 1'b1);
        chk("fp_d0", dec_y, 8'h08); tick();
        chk("fp_d1", dec_y, 8'h10); tick();
        chk("fp_d2", dec_y, 8'h40); tick();
        chk("fp_d3", dec_y, 8'h80); tick();
        chk("fp_done", dec_valid, 1'b0);

        // Two entries held while pushing and popping every cycle.
        do_reset();
        drive(1'b1, 3'd1, 1'b0);
`ifdef LINK_DECODER_PARITY_EN
        in_parity = 1'b0;
`endif
        tick();
        drive(1'b1, 3'd2, 1'b0);
`ifdef LINK_DECODER_PARITY_EN
        in_parity = 1'b0;
`endif
        tick();
        model_q = '{3'd1, 3'd2};
        for (int i = 0; i < 10; i++) begin
            k = 3'((i * 3 + 5) % 8);
            chk($sformatf("pp_v%0d", i), dec_valid, 1'b1);
            chk($sformatf("pp_y%0d", i), dec_y, 8'h01 << model_q[0]);
            drive(1'b1, k, 1'b1);
`ifdef LINK_DECODER_PARITY_EN
            in_parity = ~^k;
`endif
            tick();
            void'(model_q.pop_front());
            model_q.push_back(k);
        end
        drive(1'b0, 3'd0, 1'b1);
        chk("pp_cnt", sym_count, 16'd12);
        chk("pp_rdy", RDY_in, 1'b1);
        chk("pp_tail0", dec_y, 8'h01 << model_q[0]); tick();
        chk("pp_tail1", dec_y, 8'h01 << model_q[1]); tick();
        chk("pp_tail_empty", dec_valid, 1'b0);

        // Asynchronous reset with 3 entries queued and ovf set.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'(i + 2), 1'b0);
`ifdef LINK_DECODER_PARITY_EN
            in_parity = ~^3'(i + 2);
`endif
            tick();
        end
        tick();
        drive(1'b0, 3'd0, 1'b1);
        tick();
        drive(1'b0, 3'd0, 1'b0);
        chk("ar_pre_ovf", ovf, 1'b1);
        chk("ar_pre_v", dec_valid, 1'b1);
        chk("ar_pre_y", dec_y, 8'h08);
        #2;
        RST_N = 1'b0;
        #1;
        chk("ar_valid", dec_valid, 1'b0);
        chk("ar_y",     dec_y,     8'h00);
        chk("ar_rdy",   RDY_in,    1'b1);
        chk("ar_ovf",   ovf,       1'b0);
        chk("ar_cnt",   sym_count, 16'd0);
        RST_N = 1'b1;
        tick();

`ifdef LINK_DECODER_PARITY_EN
        do_reset();
        drive(1'b1, 3'd6, 1'b0);
        in_parity = 1'b0;
        tick();
        chk("par_perr", perr, 1'b1);
        chk("par_novalid", dec_valid, 1'b0);
        chk("par_cnt0", sym_count, 16'd0);
        in_parity = 1'b1;
        tick();
        drive(1'b0, 3'd0, 1'b0);
        chk("par_y", dec_y, 8'h40);
        chk("par_cnt1", sym_count, 16'd1);
        chk("par_sticky", perr, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/link_decoder.md
Name: link_decoder

Overview:
- Receive end of the 3-line encoded transmission link: accepts 3-bit codes (a2,a1,a0) and regenerates the 8-bit one-hot word y7..y0.
- Code n decodes to one-hot bit n set, e.g. code 3'd5 -> 8'b00100000.
- Decoded symbols are buffered in a small FIFO with valid/ready handshakes on both sides, so link bursts and consumer stalls are absorbed.
- Sits between the link pins and the downstream consumer.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >= 2).
- CNT_W, 16, width of the accepted-symbol counter.

Ports:
- CLK  in  1  Single clock; all logic on the rising edge.
- RST_N  in  1  Asynchronous, active-low reset.
- in_a2value  in  1  Code bit 2 (MSB).
- in_a1value  in  1  Code bit 1.
- in_a0value  in  1  Code bit 0.
- in_valid  in  1  Code lines hold a symbol this cycle.
- RDY_in  out  1  Block can accept a symbol; equals !full.
- dec_y  out  8  Decoded one-hot word of the FIFO head.
- dec_valid  out  1  dec_y is valid; equals !empty.
- dec_ready  in  1  Consumer takes the head this cycle.
- ovf  out  1  Sticky: a symbol was offered while full.
- sym_count  out  CNT_W  Count of accepted symbols.

Behaviour:
- Reset (RST_N low, asynchronous): FIFO empty, pointers 0, dec_valid=0, dec_y=8'h00, RDY_in=1, ovf=0, sym_count=0. Deassertion is synchronised to CLK by the integrator; internally it is treated as asynchronous.
- Push:
  - A push occurs when in_valid && RDY_in.
  - The FIFO stores the 3-bit code {a2,a1,a0}, not the one-hot word.
  - sym_count increments by 1 and wraps from 2^CNT_W-1 to 0.
- Pop: a pop occurs when dec_valid && dec_ready; the head advances.
- Output decode:
  - dec_y = 8'b1 << head_code when dec_valid=1; otherwise dec_y = 8'h00.
  - Exactly one bit is set whenever valid.
- Latency: a symbol pushed at edge N into an empty FIFO gives dec_valid=1 with its dec_y after edge N. There is no combinational path from in_* to dec_*.
- Occupancy FSM:
  - States: EMPTY, PARTIAL, FULL.
  - EMPTY -> PARTIAL on push.
  - PARTIAL -> FULL on push without pop at count DEPTH-1.
  - PARTIAL -> EMPTY on pop without push at count 1.
  - FULL -> PARTIAL on pop.
  - Push and pop in the same cycle keep the count unchanged.
- Full: RDY_in=0, and a push is never taken, even if a pop occurs in the same cycle. RDY_in rises the cycle after the pop.
- Overflow: in_valid && !RDY_in sets ovf. ovf stays set until reset. The symbol is dropped and sym_count is unchanged.
- Empty: dec_ready is ignored, and there is no pointer change.
- Order is strictly FIFO; pointers wrap modulo DEPTH.
- Reset mid-operation: contents are discarded immediately, and outputs return to their reset values in the same cycle.

Optional Feature:
- Macro: LINK_DECODER_PARITY_EN.
- Defined:
  - Adds input in_parity (1 bit). Odd parity is required, i.e. the XOR of a2, a1, a0 and in_parity must equal 1.
  - A symbol that fails the check during a push cycle is not stored and does not increment sym_count.
  - It sets the sticky output perr (1 bit, reset 0).
  - RDY_in behaviour is unchanged.
- Undefined: the in_parity and perr ports do not exist, and every offered symbol is accepted subject to RDY_in.

Decomposition:
- Package link_codec_pkg:
  - CODE_W=3, ONEHOT_W=8.
  - Typedefs code_t [2:0] and onehot_t [7:0].
  - Function code2onehot(code_t) returning onehot_t, shared with the transmit-side encoder for the inverse mapping.
- Sub-module link_fifo: generic synchronous FIFO parameterised by width and DEPTH. It provides full, empty and count; link_decoder instantiates it with width CODE_W.

Test Plan:
- Reset, then push codes 0..7 with dec_ready=1 -> dec_y sequence 01,02,04,08,10,20,40,80 one cycle after each push; sym_count=8; ovf=0.
- dec_ready=0, push 4 symbols (5,1,7,0) -> RDY_in=0 after the 4th push. A 5th push with code 3 sets ovf=1 and is dropped. Draining then yields 20,02,80,01, and sym_count=4.
- Full FIFO, pop and in_valid in the same cycle -> push not taken; RDY_in=1 the next cycle; the next push is accepted.
- PARTIAL (2 entries), push+pop every cycle for 10 cycles -> count stays 2, order preserved, dec_valid held at 1.
- Assert RST_N low mid-burst with 3 entries -> dec_valid=0, dec_y=00, RDY_in=1, ovf=0, sym_count=0 immediately (no clock edge needed).
- With LINK_DECODER_PARITY_EN: push code 6 with in_parity=0 (XOR of 1,1,0,0 = 0, fails) -> perr=1, no entry. Push code 6 with in_parity=1 (XOR = 1, passes) -> dec_y=8'h40.
